fifo_rd_packer: RTL and testbench
=================================

Name: fifo_rd_packer

Overview:
- Read-side consumer of Async_FIFO, in the rd_clk domain.
- Drains DATA_WIDTH-bit entries through the FIFO read port (rd_en/dout/empty) and packs PACK_RATIO consecutive entries into one wide word.
- Presents each word on a valid/ready stream to downstream logic.
- A flush request forces out a partial word, tagged with its byte count and a last flag.

Parameters:
- DATA_WIDTH, 8: FIFO entry width; equals the Async_FIFO DATA_WIDTH.
- PACK_RATIO, 4: entries per output word; ≥2, power of two.
- CNT_W, clogb2(PACK_RATIO): width of m_bytes. Derived, not overridden.

Ports:
- rd_clk  in  1  clock, shared with the FIFO read side.
- rst_n  in  1  synchronous active-low reset, sampled on the rd_clk rising edge.
- empty  in  1  FIFO empty flag.
- dout  in  DATA_WIDTH  FIFO read data; valid one cycle after an accepted read.
- rd_en  out  1  FIFO read strobe.
- flush  in  1  single-cycle pulse: emit any partial word.
- m_valid  out  1  output word valid.
- m_ready  in  1  downstream accept.
- m_data  out  DATA_WIDTH*PACK_RATIO  packed word.
- m_bytes  out  CNT_W+1  number of valid entries in m_data (1..PACK_RATIO).
- m_last  out  1  word was produced by a flush.
- flush_done  out  1  one-cycle pulse when a flush completes.

Behaviour:
- Reset: the clock and reset are a single clock, with a synchronous active-low reset.
  - While rst_n=0 at a rising edge, all outputs and state go to 0: rd_en, m_valid, m_data, m_bytes, m_last, flush_done, accumulator, fill count cnt, in-flight bit, state = FILL.
  - Reset mid-word discards the partial data; no output is produced for it.
- Accepted read: rd_en=1 and empty=0 in the same cycle. dout is captured at the end of the next cycle (rd_vld pipeline bit). rd_en is never asserted while empty=1.
- rd_en is combinational: rd_en = !empty && state==FILL && (cnt + inflight < PACK_RATIO). At most PACK_RATIO entries are ever pulled for one word.
- Packing order (default): entry k goes to m_data[k*DATA_WIDTH +: DATA_WIDTH]. The first read lands in the LSBs.
- Word complete: the PACK_RATIO-th captured entry completes the word.
  - If the output slot is free (!m_valid, or m_valid && m_ready that cycle), the word loads directly into the output: m_valid=1, m_bytes=PACK_RATIO, m_last=0, and cnt returns to 0.
  - Latency: rd_en cycle of the final entry at t gives m_valid=1 at t+2.
  - If the slot is busy, go to HOLD. rd_en stays 0 until the slot frees, then load the next cycle and return to FILL.
- Output stream: m_data/m_bytes/m_last hold stable while m_valid && !m_ready. m_valid clears on a handshake unless a new word loads the same edge. Back-to-back words are allowed: one word per cycle is never required, but no bubble is needed beyond the pack latency.
- States:
  - FILL: normal packing.
  - HOLD: accumulator full, output busy.
  - FLUSH: a flush is pending.
- flush handling:
  - flush in FILL or HOLD sets FLUSH and blocks new reads.
  - FLUSH waits for any in-flight entry to land, then for a free output slot.
  - If cnt>0, emit the partial word: unused upper entries are 0, m_bytes=cnt, m_last=1.
  - If cnt==0, emit nothing.
  - In both cases, pulse flush_done on the cycle the word loads, or on the first free cycle, then return to FILL.
  - If flush arrives in HOLD, the full word is emitted first with m_last=1 and m_bytes=PACK_RATIO.
  - A flush arriving while already in FLUSH is ignored.
- If flush and the final-entry capture coincide, the word is emitted full with m_last=1.

Optional Feature:
- PACKER_MSB_FIRST_EN defined: entry k goes to m_data[(PACK_RATIO-1-k)*DATA_WIDTH +: DATA_WIDTH]. The first read lands in the MSBs, and a partial word is MSB-aligned with zeros in the LSBs.
- Undefined: LSB-first packing as above.
- All timing is identical in both builds.

Test Plan:
- Reset hold:
  - Stimulus: rst_n=0 for 5 cycles with empty=0.
  - Required: rd_en=0, m_valid=0, all outputs 0. After release, rd_en=1 on the first cycle.
- Basic pack:
  - Stimulus: FIFO writes 17, 20, 800, 801 (truncated to 8 bits: 0x11, 0x14, 0x20, 0x21), m_ready=1.
  - Required: one word m_data=0x21201411, m_bytes=4, m_last=0. With PACKER_MSB_FIRST_EN: 0x11142021.
- Backpressure:
  - Stimulus: 8 entries 1..8 written with m_ready=0.
  - Required: first word 0x04030201 is held stable and the block enters HOLD with rd_en=0. Raise m_ready: 0x04030201 is accepted, then 0x08070605.
- Partial flush:
  - Stimulus: write 5, 6, 7, then pulse flush.
  - Required: m_data=0x00070605, m_bytes=3, m_last=1, flush_done pulses once. No further reads while empty.
- Empty flush:
  - Stimulus: flush with cnt=0 and the FIFO empty.
  - Required: no m_valid, flush_done pulses one cycle later.
- Mid-word reset:
  - Stimulus: after 2 entries are captured, rst_n=0 for one cycle; then write 9, 10, 11, 12.
  - Required: the next word is 0x0C0B0A09; the stale entries never appear.

Source files
------------

// File: rtl/fifo_rd_packer.sv
// rtl/fifo_rd_packer.sv - packs DATA_WIDTH FIFO entries into PACK_RATIO-wide stream words with flush support
// Optional: define PACKER_MSB_FIRST_EN to place the first entry in the MSBs.
module fifo_rd_packer #(
    parameter int DATA_WIDTH = 8,
    parameter int PACK_RATIO = 4,
    localparam int CNT_W = $clog2(PACK_RATIO)
) (
    input  logic                             rd_clk,
    input  logic                             rst_n,
    input  logic                             empty,
    input  logic [DATA_WIDTH-1:0]            dout,
    output logic                             rd_en,
    input  logic                             flush,
    output logic                             m_valid,
    input  logic                             m_ready,
    output logic [DATA_WIDTH*PACK_RATIO-1:0] m_data,
    output logic [CNT_W:0]                   m_bytes,
    output logic                             m_last,
    output logic                             flush_done
);

    localparam int W = DATA_WIDTH * PACK_RATIO;
`ifdef PACKER_MSB_FIRST_EN
    localparam bit MSB_FIRST = 1'b1;
`else
    localparam bit MSB_FIRST = 1'b0;
`endif
    localparam logic [CNT_W:0]   PR_C   = (CNT_W+1)'(PACK_RATIO);
    localparam logic [CNT_W:0]   LAST_C = (CNT_W+1)'(PACK_RATIO - 1);
    localparam logic [CNT_W+1:0] PR_W   = (CNT_W+2)'(PACK_RATIO);

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        HOLD  = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t         state, state_nx;
    logic [W-1:0]   acc, acc_nx, acc_ins, acc_cur;
    logic [CNT_W:0] cnt, cnt_nx, cnt_cur;
    logic           inflight;
    logic [CNT_W+1:0] pending;
    logic           slot_free;
    logic           last_entry;
    logic           load;
    logic [W-1:0]   load_data;
    logic [CNT_W:0] load_bytes;
    logic           load_last;
    logic           done_nx;

    // Entries already captured plus the one still in flight bound how many we may request.
    assign pending    = {1'b0, cnt} + {{(CNT_W+1){1'b0}}, inflight};
    assign rd_en      = rst_n && !empty && (state == FILL) && (pending < PR_W);
    assign slot_free  = !m_valid || m_ready;
    assign last_entry = inflight && (cnt == LAST_C);

    always_comb begin
        acc_ins = acc;
        for (int k = 0; k < PACK_RATIO; k++) begin
            if (cnt == (CNT_W+1)'(k)) begin
                acc_ins[(MSB_FIRST ? PACK_RATIO-1-k : k)*DATA_WIDTH +: DATA_WIDTH] = dout;
            end
        end
    end

    assign acc_cur = inflight ? acc_ins : acc;
    assign cnt_cur = inflight ? cnt + (CNT_W+1)'(1) : cnt;

    always_comb begin
        state_nx   = state;
        acc_nx     = acc_cur;
        cnt_nx     = cnt_cur;
        load       = 1'b0;
        load_data  = acc_cur;
        load_bytes = cnt_cur;
        load_last  = 1'b0;
        done_nx    = 1'b0;
        case (state)
            FILL: begin
                if (last_entry) begin
                    if (slot_free) begin
                        load      = 1'b1;
                        load_last = flush;
                        done_nx   = flush;
                        acc_nx    = '0;
                        cnt_nx    = '0;
                    end else begin
                        state_nx = flush ? FLUSH : HOLD;
                    end
                end else if (flush) begin
                    state_nx = FLUSH;
                end
            end
            HOLD: begin
                // A flush here re-routes the full word through FLUSH so it leaves tagged last.
                if (flush) begin
                    state_nx = FLUSH;
                end else if (slot_free) begin
                    load     = 1'b1;
                    acc_nx   = '0;
                    cnt_nx   = '0;
                    state_nx = FILL;
                end
            end
            FLUSH: begin
                if (!inflight && slot_free) begin
                    load      = (cnt != '0);
                    load_last = 1'b1;
                    done_nx   = 1'b1;
                    acc_nx    = '0;
                    cnt_nx    = '0;
                    state_nx  = FILL;
                end
            end
            default: state_nx = FILL;
        endcase
    end

    always_ff @(posedge rd_clk) begin
        if (!rst_n) begin
            state      <= FILL;
            acc        <= '0;
            cnt        <= '0;
            inflight   <= 1'b0;
            m_valid    <= 1'b0;
            m_data     <= '0;
            m_bytes    <= '0;
            m_last     <= 1'b0;
            flush_done <= 1'b0;
        end else begin
            state      <= state_nx;
            acc        <= acc_nx;
            cnt        <= cnt_nx;
            inflight   <= rd_en;
            flush_done <= done_nx;
            if (load) begin
                m_valid <= 1'b1;
                m_data  <= load_data;
                m_bytes <= load_bytes;
                m_last  <= load_last;
            end else if (m_ready) begin
                m_valid <= 1'b0;
            end
        end
    end

    logic unused_ok;
    assign unused_ok = ^PR_C;

endmodule

// File: tb/tb_fifo_rd_packer.sv
// tb/tb_fifo_rd_packer.sv - directed self-checking bench for fifo_rd_packer
module tb_fifo_rd_packer;

    logic        rd_clk = 1'b0;
    logic        rst_n;
    logic        empty;
    logic [7:0]  dout;
    logic        rd_en;
    logic        flush;
    logic        m_valid;
    logic        m_ready;
    logic [31:0] m_data;
    logic [2:0]  m_bytes;
    logic        m_last;
    logic        flush_done;

    always #5 rd_clk = ~rd_clk;

    fifo_rd_packer #(.DATA_WIDTH(8), .PACK_RATIO(4)) dut (
        .rd_clk     (rd_clk),
        .rst_n      (rst_n),
        .empty      (empty),
        .dout       (dout),
        .rd_en      (rd_en),
        .flush      (flush),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_bytes    (m_bytes),
        .m_last     (m_last),
        .flush_done (flush_done)
    );

`ifdef PACKER_MSB_FIRST_EN
    localparam logic [31:0] EXP_BASIC = 32'h11142021;
    localparam logic [31:0] EXP_BP0   = 32'h01020304;
    localparam logic [31:0] EXP_BP1   = 32'h05060708;
    localparam logic [31:0] EXP_PART  = 32'h05060700;
    localparam logic [31:0] EXP_RST   = 32'h090A0B0C;
    localparam logic [31:0] EXP_HF0   = 32'h21222324;
    localparam logic [31:0] EXP_HF1   = 32'h25262728;
`else
    localparam logic [31:0] EXP_BASIC = 32'h21201411;
    localparam logic [31:0] EXP_BP0   = 32'h04030201;
    localparam logic [31:0] EXP_BP1   = 32'h08070605;
    localparam logic [31:0] EXP_PART  = 32'h00070605;
    localparam logic [31:0] EXP_RST   = 32'h0C0B0A09;
    localparam logic [31:0] EXP_HF0   = 32'h24232221;
    localparam logic [31:0] EXP_HF1   = 32'h28272625;
`endif

    // FIFO model: one-cycle read latency, pointers owned by separate processes
    logic [7:0] mem [0:63];
    int wr_ptr = 0;
    int rd_ptr = 0;
    assign empty = (wr_ptr == rd_ptr);

    always @(posedge rd_clk) begin
        if (rd_en && !empty) begin
            dout   <= mem[rd_ptr % 64];
            rd_ptr <= rd_ptr + 1;
        end
    end

    logic [31:0] w_data  [0:31];
    logic [2:0]  w_bytes [0:31];
    logic        w_last  [0:31];
    int w_n  = 0;
    int fd_n = 0;
    bit viol = 1'b0;

    always @(negedge rd_clk) begin
        if (m_valid && m_ready) begin
            w_data[w_n % 32]  = m_data;
            w_bytes[w_n % 32] = m_bytes;
            w_last[w_n % 32]  = m_last;
            w_n = w_n + 1;
        end
        if (flush_done) fd_n = fd_n + 1;
        if (rd_en && empty) viol = 1'b1;
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [7:0] v);
        mem[wr_ptr % 64] = v;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic step();
        @(posedge rd_clk);
        #1;
    endtask

    task automatic wait_words(input int target, input int budget);
        int i;
        i = 0;
        while (w_n < target && i < budget) begin
            @(negedge rd_clk);
            i++;
        end
        if (w_n < target) check("word_timeout", 64'(w_n), 64'(target));
    endtask

    task automatic pulse_flush();
        step();
        flush = 1'b1;
        step();
        flush = 1'b0;
    endtask

    int base;
    int fd_base;
    logic v5, v6;

    initial begin
        rst_n   = 1'b0;
        flush   = 1'b0;
        m_ready = 1'b1;
        push(8'd17); push(8'd20); push(8'(800)); push(8'(801));

        // Reset hold with data available
        for (int c = 0; c < 5; c++) begin
            @(negedge rd_clk);
            check("rst_rd_en", 64'(rd_en), 64'd0);
            check("rst_m_valid", 64'(m_valid), 64'd0);
        end
        check("rst_m_data", 64'(m_data), 64'd0);
        check("rst_m_bytes", 64'(m_bytes), 64'd0);
        check("rst_m_last", 64'(m_last), 64'd0);
        check("rst_flush_done", 64'(flush_done), 64'd0);

        // Basic pack: final read in cycle 4, word visible in cycle 6
        step();
        rst_n = 1'b1;
        base = w_n;
        @(negedge rd_clk);
        check("rel_rd_en", 64'(rd_en), 64'd1);
        repeat (4) @(negedge rd_clk);
        v5 = m_valid;
        @(negedge rd_clk);
        v6 = m_valid;
        check("lat_cycle5", 64'(v5), 64'd0);
        check("lat_cycle6", 64'(v6), 64'd1);
        wait_words(base + 1, 10);
        check("basic_data", 64'(w_data[base % 32]), 64'(EXP_BASIC));
        check("basic_bytes", 64'(w_bytes[base % 32]), 64'd4);
        check("basic_last", 64'(w_last[base % 32]), 64'd0);

        // Backpressure into HOLD
        step();
        m_ready = 1'b0;
        for (int i = 1; i <= 8; i++) push(8'(i));
        repeat (20) @(negedge rd_clk);
        check("bp_valid", 64'(m_valid), 64'd1);
        check("bp_data_a", 64'(m_data), 64'(EXP_BP0));
        check("bp_state_hold", 64'(dut.state), 64'd1);
        check("bp_rd_en", 64'(rd_en), 64'd0);
        repeat (3) @(negedge rd_clk);
        check("bp_data_b", 64'(m_data), 64'(EXP_BP0));
        base = w_n;
        step();
        m_ready = 1'b1;
        wait_words(base + 2, 20);
        check("bp_w0", 64'(w_data[base % 32]), 64'(EXP_BP0));
        check("bp_w1", 64'(w_data[(base + 1) % 32]), 64'(EXP_BP1));
        check("bp_w1_bytes", 64'(w_bytes[(base + 1) % 32]), 64'd4);
        check("bp_w1_last", 64'(w_last[(base + 1) % 32]), 64'd0);

        // Partial flush
        repeat (4) step();
        push(8'd5); push(8'd6); push(8'd7);
        repeat (8) step();
        base = w_n;
        fd_base = fd_n;
        pulse_flush();
        repeat (8) @(negedge rd_clk);
        check("part_count", 64'(w_n - base), 64'd1);
        check("part_data", 64'(w_data[base % 32]), 64'(EXP_PART));
        check("part_bytes", 64'(w_bytes[base % 32]), 64'd3);
        check("part_last", 64'(w_last[base % 32]), 64'd1);
        check("part_done", 64'(fd_n - fd_base), 64'd1);
        check("part_no_reads", 64'(rd_ptr), 64'(wr_ptr));

        // Empty flush: flush_done appears the cycle after FLUSH is entered
        base = w_n;
        fd_base = fd_n;
        step();
        flush = 1'b1;
        @(negedge rd_clk);
        check("eflush_done_c0", 64'(flush_done), 64'd0);
        step();
        flush = 1'b0;
        @(negedge rd_clk);
        check("eflush_done_c1", 64'(flush_done), 64'd0);
        @(negedge rd_clk);
        check("eflush_done_c2", 64'(flush_done), 64'd1);
        repeat (5) @(negedge rd_clk);
        check("eflush_pulses", 64'(fd_n - fd_base), 64'd1);
        check("eflush_no_word", 64'(w_n - base), 64'd0);

        // Mid-word reset discards captured entries
        step();
        push(8'hAA); push(8'hBB);
        repeat (5) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        base = w_n;
        push(8'd9); push(8'd10); push(8'd11); push(8'd12);
        wait_words(base + 1, 20);
        repeat (4) @(negedge rd_clk);
        check("mrst_count", 64'(w_n - base), 64'd1);
        check("mrst_data", 64'(w_data[base % 32]), 64'(EXP_RST));
        check("mrst_bytes", 64'(w_bytes[base % 32]), 64'd4);

        // Flush while holding a full word: that word leaves tagged last
        step();
        m_ready = 1'b0;
        for (int i = 0; i < 8; i++) push(8'(8'h21 + i));
        repeat (20) step();
        base = w_n;
        fd_base = fd_n;
        pulse_flush();
        m_ready = 1'b1;
        wait_words(base + 2, 20);
        repeat (4) @(negedge rd_clk);
        check("hf_w0", 64'(w_data[base % 32]), 64'(EXP_HF0));
        check("hf_w0_last", 64'(w_last[base % 32]), 64'd0);
        check("hf_w1", 64'(w_data[(base + 1) % 32]), 64'(EXP_HF1));
        check("hf_w1_bytes", 64'(w_bytes[(base + 1) % 32]), 64'd4);
        check("hf_w1_last", 64'(w_last[(base + 1) % 32]), 64'd1);
        check("hf_done", 64'(fd_n - fd_base), 64'd1);

        check("rd_en_while_empty", 64'(viol), 64'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
